servant_wb_rr_arbiter: RTL



---
 rtl/servant_arb_pkg.sv | 18 +
 rtl/servant_rr_pick.sv | 26 ++
 rtl/servant_wb_rr_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/servant_arb_pkg.sv
// Shared types and helpers for the servant Wishbone memory-port arbiter.
// Imported by the arbiter top and its priority-encoder sub-module.
package servant_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam string MODE_RR    = "RR";
    localparam string MODE_FIXED = "FIXED";

    // A disabled timeout still needs a legal width for any declared counter.
    function automatic int tmo_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/servant_rr_pick.sv
// Combinational rotating priority encoder: one-hot winner of req,
// searching upward from ptr (or from 0 when fixed) with wrap-around.
module servant_rr_pick
    import servant_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          fixed,
    output logic [N-1:0]  win
);

    logic [PW-1:0] sh;
    logic [N-1:0]  rot;
    logic [N-1:0]  rot_win;

    assign sh = fixed ? '0 : ptr;

    // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
    assign rot     = N'({req, req} >> sh);
    assign rot_win = rot & (-rot);
    assign win     = N'(({rot_win, rot_win} << sh) >> N);

endmodule

// File: rtl/servant_wb_rr_arbiter.sv
// N-master to 1-slave Wishbone arbiter for the servant memory port with
// a registered grant held per transaction, abort and optional timeout.
module servant_wb_rr_arbiter
    import servant_arb_pkg::*;
#(
    parameter int    NUM_MASTERS = 3,
    parameter int    AW          = 32,
    parameter int    DW          = 32,
    parameter string MODE        = "RR",
    parameter int    TIMEOUT     = 0,
    localparam int   SW          = DW / 8
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    input  logic [NUM_MASTERS*AW-1:0] i_m_adr,
    input  logic [NUM_MASTERS*DW-1:0] i_m_dat,
    input  logic [NUM_MASTERS*SW-1:0] i_m_sel,
    input  logic [NUM_MASTERS-1:0]    i_m_we,
    input  logic [NUM_MASTERS-1:0]    i_m_cyc,
    output logic [DW-1:0]             o_m_rdt,
    output logic [NUM_MASTERS-1:0]    o_m_ack,
    output logic [NUM_MASTERS-1:0]    o_m_err,
    output logic [AW-1:0]             o_s_adr,
    output logic [DW-1:0]             o_s_dat,
    output logic [SW-1:0]             o_s_sel,
    output logic                      o_s_we,
    output logic                      o_s_cyc,
    input  logic [DW-1:0]             i_s_rdt,
    input  logic                      i_s_ack,
    output logic [NUM_MASTERS-1:0]    o_grant
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam bit IS_FIXED = (MODE == MODE_FIXED);

    arb_state_t             state_q;
    arb_state_t             state_d;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [PW-1:0]          rr_ptr_q;
    logic [PW-1:0]          rr_ptr_d;
    logic [NUM_MASTERS-1:0] err_q;
    logic [NUM_MASTERS-1:0] err_d;
    logic [NUM_MASTERS-1:0] win;

    logic [AW-1:0] adr_g;
    logic [DW-1:0] dat_g;
    logic [SW-1:0] sel_g;
    logic          we_g;
    logic          cyc_g;
    logic [PW-1:0] gidx;
    logic [PW-1:0] ptr_next;
    logic          in_grant;
    logic          tmo_hit;

    servant_rr_pick #(
        .N  (NUM_MASTERS),
        .PW (PW)
    ) u_pick (
        .req   (i_m_cyc),
        .ptr   (rr_ptr_q),
        .fixed (IS_FIXED),
        .win   (win)
    );

    // Grant is one-hot, so the slice mux is a plain priority scan.
    always_comb begin
        adr_g = '0;
        dat_g = '0;
        sel_g = '0;
        we_g  = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                adr_g = i_m_adr[k*AW +: AW];
                dat_g = i_m_dat[k*DW +: DW];
                sel_g = i_m_sel[k*SW +: SW];
                we_g  = i_m_we[k];
                gidx  = PW'(k);
            end
        end
    end

    assign cyc_g    = |(grant_q & i_m_cyc);
    assign in_grant = (state_q == GRANT);
    assign ptr_next = (gidx == PW'(NUM_MASTERS - 1)) ? '0
                                                     : gidx + PW'(1);

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int TW = tmo_width(TIMEOUT);
            logic [TW-1:0] tmo_cnt;

            // Held at zero in IDLE so it starts from 0 on GRANT entry.
            always_ff @(posedge wb_clk or posedge wb_rst) begin
                if (wb_rst) begin
                    tmo_cnt <= '0;
                end else if (state_q == IDLE) begin
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end

            assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (|i_m_cyc) begin
                    state_d = GRANT;
                    grant_d = win;
                end
            end
            GRANT: begin
                if (i_s_ack || !cyc_g || tmo_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                    if (!IS_FIXED) begin
                        rr_ptr_d = ptr_next;
                    end
                end
                // Ack and abort both outrank a coincident timeout.
                if (!i_s_ack && cyc_g && tmo_hit) begin
                    err_d = grant_q;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign o_s_cyc = in_grant & cyc_g;
    assign o_s_adr = in_grant ? adr_g : '0;
    assign o_s_dat = in_grant ? dat_g : '0;
    assign o_s_sel = in_grant ? sel_g : '0;
    assign o_s_we  = in_grant & we_g;
    assign o_m_ack = (in_grant && i_s_ack) ? grant_q : '0;
    assign o_m_rdt = i_s_rdt;
    assign o_m_err = err_q;
    assign o_grant = grant_q;

endmodule
